// File: rtl/io_uart_tx_pkg.sv
// Shared CPU IO definitions: UART frame constants and the transmitter state encoding.
package cpu_io_pkg;
  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/io_uart_tx_if.sv
// Byte-in / serial-out handshake between the IO register side and the UART transmitter.
interface io_uart_tx_if;
  import cpu_io_pkg::*;

  logic                      tx_start;
  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx;
  logic                      busy;
  logic                      done;

  modport master (output tx_start, output tx_data, input tx, input busy, input done);
  modport slave  (input tx_start, input tx_data, output tx, output busy, output done);
endinterface

// File: rtl/io_uart_tx_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, ticks on the last count and wraps.
module io_baud_gen
  import cpu_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/io_uart_tx.sv
// 8N1 UART transmitter: latches the IO byte on a start strobe and shifts it out LSB first.
module io_uart_tx
  import cpu_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input logic        clk,
  input logic        rst,
  io_uart_tx_if.slave bus
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("io_uart_tx: CLKS_PER_BIT must be >= 2");
  end

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_t               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [2:0]                bit_q, bit_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      baud_clr;
  logic                      baud_tick;

  io_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear_i(baud_clr),
    .tick_o (baud_tick)
  );

  // tx is registered and updated at the wrap edge so each bit holds for a full period
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    baud_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.tx_start) begin
          state_d  = START;
          shreg_d  = bus.tx_data;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
          baud_clr = 1'b1;
        end
      end
      START: begin
        if (baud_tick) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx at CLKS_PER_BIT=4: frame table plus reset/back-to-back sequences.
module tb_io_uart_tx;

  localparam int C = 4;
  localparam int FRAME = 10 * C;

  logic clk = 1'b0;
  logic rst;

  io_uart_tx_if bus ();

  io_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected slot values are written slot 0 first (MSB) to slot 9 (LSB).
  typedef struct {
    logic [7:0] data;
    logic [9:0] slots;
    int         pulse_j;
    bit         scramble;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Launch one frame with a single-cycle strobe and check it cycle by cycle.
  task automatic run_frame(input logic [7:0] d, input logic [9:0] slots,
                           input int pulse_j, input bit scramble, input string tag);
    logic [9:0] slot_bad;
    int busy_cnt, done_cnt, done_pos, idle_bad;
    slot_bad = '0; busy_cnt = 0; done_cnt = 0; done_pos = -1; idle_bad = 0;
    bus.tx_start = 1'b1;
    bus.tx_data  = d;
    @(posedge clk);
    for (int j = 0; j < FRAME + 6; j++) begin
      @(negedge clk);
      if (j < FRAME) begin
        if (bus.tx !== slots[9 - j / C]) slot_bad[j / C] = 1'b1;
        if (bus.busy !== 1'b1) idle_bad++;
      end else if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
        idle_bad++;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_pos = j;
      end
      bus.tx_start = (j == pulse_j);
      if (j == pulse_j) bus.tx_data = 8'h3C;
      if (scramble) bus.tx_data = 8'($urandom);
    end
    bus.tx_start = 1'b0;
    for (int k = 0; k < 10; k++) chk($sformatf("%s slot%0d", tag, k), 32'(slot_bad[k]), 32'd0);
    chk({tag, " busy_cycles"}, busy_cnt, FRAME);
    chk({tag, " done_count"}, done_cnt, 1);
    chk({tag, " done_cycle"}, done_pos, FRAME);
    chk({tag, " line_state_errs"}, idle_bad, 0);
  endtask

  initial begin
    int bad_tx, bad_busy, bad_done, done_cnt, act_cnt;
    logic [9:0] zslots;

    vecs[0] = '{8'hA5, 10'b0101001011, -1, 1'b0};
    vecs[1] = '{8'hA5, 10'b0101001011, 15, 1'b0};
    vecs[2] = '{8'h81, 10'b0100000011, -1, 1'b1};
    vecs[3] = '{8'h3C, 10'b0001111001, -1, 1'b0};
    vecs[4] = '{8'hFF, 10'b0111111111, -1, 1'b0};

    // Reset: three cycles held, then 20 quiet cycles.
    rst = 1'b1;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset tx", 32'(bus.tx), 32'd1);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    act_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) act_cnt++;
    end
    chk("idle after reset", act_cnt, 0);

    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].data, vecs[v].slots, vecs[v].pulse_j, vecs[v].scramble,
                $sformatf("vec%0d", v));
      repeat (2) @(negedge clk);
    end

    // Back-to-back: strobe held high, 0x00 frames repeat every FRAME+1 cycles.
    zslots = 10'b0000000001;
    bad_tx = 0; bad_busy = 0; bad_done = 0; done_cnt = 0;
    bus.tx_start = 1'b1;
    bus.tx_data  = 8'h00;
    @(posedge clk);
    for (int j = 0; j < 3 * (FRAME + 1); j++) begin
      int m;
      @(negedge clk);
      m = j % (FRAME + 1);
      if (bus.tx !== ((m < FRAME) ? zslots[9 - m / C] : 1'b1)) bad_tx++;
      if (bus.busy !== (m < FRAME)) bad_busy++;
      if (bus.done !== (m == FRAME)) bad_done++;
      if (bus.done === 1'b1) done_cnt++;
    end
    bus.tx_start = 1'b0;
    chk("b2b tx", bad_tx, 0);
    chk("b2b busy", bad_busy, 0);
    chk("b2b done_pos", bad_done, 0);
    chk("b2b done_count", done_cnt, 3);
    repeat (C * 12) @(negedge clk);

    // Reset mid-frame at cycle 20 of a 0xFF frame, with tx_start asserted on the same edge.
    bad_tx = 0;
    bus.tx_start = 1'b1;
    bus.tx_data  = 8'hFF;
    @(posedge clk);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus.tx !== ((j < C) ? 1'b0 : 1'b1)) bad_tx++;
      bus.tx_start = 1'b0;
    end
    chk("abort pre tx", bad_tx, 0);
    rst = 1'b1;
    bus.tx_start = 1'b1;
    @(negedge clk);
    chk("abort tx", 32'(bus.tx), 32'd1);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    bus.tx_start = 1'b0;
    act_cnt = 0;
    for (int j = 0; j < FRAME + 10; j++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.tx !== 1'b1) act_cnt++;
    end
    chk("abort quiet", act_cnt, 0);

    run_frame(8'h55, 10'b0101010101, -1, 1'b0, "post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
